// File: rtl/priority_req_latch_v.sv
// Request capture and grant handshake stage in front of the 4:2 priority encoder.
// Requests become sticky pending bits; the encoder's pick is frozen and offered over valid/ready.
module priority_req_latch_v #(
    parameter int P_EDGE = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    output logic [3:0] o_pending,
    input  logic [1:0] i_enc_code,
    input  logic       i_enc_valid,
    output logic       o_grant_valid,
    output logic [1:0] o_grant_code,
    input  logic       i_grant_ready,
    output logic [3:0] o_lost,
    input  logic       i_lost_clr
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] req_q;
    logic [3:0] cap;
    logic [3:0] clr;
    logic [3:0] pending_next;
    logic [3:0] lost_next;
    logic       accept;
    logic       load_grant;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_q <= 4'b0000;
        end else begin
            req_q <= i_req;
        end
    end

    always_comb begin
        cap = (P_EDGE != 0) ? (i_req & ~req_q) : i_req;
    end

    // A capture landing on the line being serviced re-arms it instead of being dropped.
    always_comb begin
        accept       = (state == OFFER) & i_grant_ready;
        clr          = accept ? (4'b0001 << o_grant_code) : 4'b0000;
        pending_next = (o_pending & ~clr) | cap;
        lost_next    = i_lost_clr ? 4'b0000 : (o_lost | (cap & o_pending & ~clr));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pending <= 4'b0000;
            o_lost    <= 4'b0000;
        end else begin
            o_pending <= pending_next;
            o_lost    <= lost_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Once a code is offered it is held until accepted; newer requests never preempt it.
    always_comb begin
        state_next = state;
        load_grant = 1'b0;
        case (state)
            IDLE: begin
                if (i_enc_valid) begin
                    load_grant = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (i_grant_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_grant_code <= 2'b00;
        end else if (load_grant) begin
            o_grant_code <= i_enc_code;
        end
    end

    assign o_grant_valid = (state == OFFER);

endmodule

// File: tb/tb_priority_req_latch_v.sv
// Bench for priority_req_latch_v: directed scenarios plus randomized run against a behavioural model.
module tb_priority_req_latch_v;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic       lost_clr;
    logic [3:0] pend;
    logic       gv;
    logic [1:0] gcode;
    logic [3:0] lost;
    logic [1:0] enc_code;
    logic       enc_valid;

    logic [3:0] req_b;
    logic       ready_b;
    logic       lost_clr_b;
    logic [3:0] pend_b;
    logic       gv_b;
    logic [1:0] gcode_b;
    logic [3:0] lost_b;
    logic [1:0] enc_code_b;
    logic       enc_valid_b;

    int checks = 0;
    int errors = 0;

    // behavioural model state (edge-mode instance)
    logic [3:0] m_pend;
    logic [3:0] m_lost;
    logic       m_offer;
    logic [1:0] m_code;
    logic [3:0] m_reqq;

    priority_req_latch_v #(.P_EDGE(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .o_pending(pend),
        .i_enc_code(enc_code), .i_enc_valid(enc_valid),
        .o_grant_valid(gv), .o_grant_code(gcode), .i_grant_ready(ready),
        .o_lost(lost), .i_lost_clr(lost_clr)
    );

    priority_req_latch_v #(.P_EDGE(0)) dut_lvl (
        .i_clk(clk), .i_rst(rst), .i_req(req_b), .o_pending(pend_b),
        .i_enc_code(enc_code_b), .i_enc_valid(enc_valid_b),
        .o_grant_valid(gv_b), .o_grant_code(gcode_b), .i_grant_ready(ready_b),
        .o_lost(lost_b), .i_lost_clr(lost_clr_b)
    );

    // Combinational 4:2 priority encoder, line 0 highest.
    always_comb begin
        enc_valid = |pend;
        enc_code  = pend[0] ? 2'd0 : pend[1] ? 2'd1 : pend[2] ? 2'd2 : 2'd3;
        enc_valid_b = |pend_b;
        enc_code_b  = pend_b[0] ? 2'd0 : pend_b[1] ? 2'd1 : pend_b[2] ? 2'd2 : 2'd3;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin : model
        logic [3:0] cap;
        logic [3:0] np;
        logic [3:0] nl;
        logic       acc;
        logic       hit;
        int         low;
        if (rst) begin
            m_pend  <= 4'b0000;
            m_lost  <= 4'b0000;
            m_offer <= 1'b0;
            m_code  <= 2'b00;
            m_reqq  <= 4'b0000;
        end else begin
            cap = req & ~m_reqq;
            acc = m_offer && ready;
            for (int n = 0; n < 4; n++) begin
                hit   = acc && (n == int'(m_code));
                np[n] = (m_pend[n] && !hit) || cap[n];
                nl[n] = !lost_clr && (m_lost[n] || (cap[n] && m_pend[n] && !hit));
            end
            m_pend <= np;
            m_lost <= nl;
            m_reqq <= req;
            if (!m_offer) begin
                low = -1;
                for (int n = 3; n >= 0; n--) if (m_pend[n]) low = n;
                if (low >= 0) begin
                    m_offer <= 1'b1;
                    m_code  <= 2'(low);
                end
            end else if (ready) begin
                m_offer <= 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; req = 4'b0; ready = 1'b0; lost_clr = 1'b0;
        req_b = 4'b0; ready_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b want 0000", pend); end
        checks++; if (gv !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", gv); end
        checks++; if (gcode !== 2'b00) begin errors++; $display("FAIL reset_code: got %b want 00", gcode); end
        checks++; if (lost !== 4'b0000) begin errors++; $display("FAIL reset_lost: got %b want 0000", lost); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        @(negedge clk); req = 4'b0000;
        checks++; if (pend !== 4'b0100) begin errors++; $display("FAIL single_pending: got %b want 0100", pend); end
        checks++; if (gv !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", gv); end
        @(negedge clk);
        checks++; if (gv !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", gv); end
        checks++; if (gcode !== 2'b10) begin errors++; $display("FAIL single_code: got %b want 10", gcode); end
        ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL single_cleared: got %b want 0000", pend); end
        checks++; if (gv !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", gv); end
    endtask

    task automatic test_priority();
        logic [1:0] exp_codes [3];
        int idx;
        int last;
        exp_codes[0] = 2'b00; exp_codes[1] = 2'b01; exp_codes[2] = 2'b11;
        do_reset();
        req = 4'b1011; ready = 1'b1;
        @(negedge clk); req = 4'b0000;
        checks++; if (pend !== 4'b1011) begin errors++; $display("FAIL prio_pending: got %b want 1011", pend); end
        idx = 0; last = -2;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (gv === 1'b1) begin
                if (idx < 3) begin
                    checks++; if (gcode !== exp_codes[idx]) begin errors++; $display("FAIL prio_code%0d: got %b want %b", idx, gcode, exp_codes[idx]); end
                    if (idx > 0) begin
                        checks++; if (c - last !== 2) begin errors++; $display("FAIL prio_spacing%0d: got %0d want 2", idx, c - last); end
                    end
                end
                last = c;
                idx++;
            end
        end
        ready = 1'b0;
        checks++; if (idx !== 3) begin errors++; $display("FAIL prio_count: got %0d want 3", idx); end
        checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL prio_final_pending: got %b want 0000", pend); end
    endtask

    task automatic test_no_preempt();
        do_reset();
        req = 4'b1000;
        @(negedge clk); req = 4'b0000;
        @(negedge clk);
        checks++; if (gcode !== 2'b11 || gv !== 1'b1) begin errors++; $display("FAIL nopre_offer: got v=%b code=%b want v=1 code=11", gv, gcode); end
        req = 4'b0001;
        @(negedge clk); req = 4'b0000;
        checks++; if (gcode !== 2'b11) begin errors++; $display("FAIL nopre_hold1: got %b want 11", gcode); end
        checks++; if (pend !== 4'b1001) begin errors++; $display("FAIL nopre_pending: got %b want 1001", pend); end
        @(negedge clk);
        checks++; if (gcode !== 2'b11 || gv !== 1'b1) begin errors++; $display("FAIL nopre_hold2: got v=%b code=%b want v=1 code=11", gv, gcode); end
        ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        checks++; if (gv !== 1'b0 || pend !== 4'b0001) begin errors++; $display("FAIL nopre_accept: got v=%b pend=%b want v=0 pend=0001", gv, pend); end
        @(negedge clk);
        checks++; if (gv !== 1'b1 || gcode !== 2'b00) begin errors++; $display("FAIL nopre_next: got v=%b code=%b want v=1 code=00", gv, gcode); end
        ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL nopre_drain: got %b want 0000", pend); end
    endtask

    task automatic test_collision_lost();
        do_reset();
        req = 4'b0010;
        @(negedge clk); req = 4'b0000;
        @(negedge clk);
        checks++; if (gv !== 1'b1 || gcode !== 2'b01) begin errors++; $display("FAIL coll_offer: got v=%b code=%b want v=1 code=01", gv, gcode); end
        ready = 1'b1; req = 4'b0010;
        @(negedge clk); ready = 1'b0; req = 4'b0000;
        checks++; if (pend !== 4'b0010) begin errors++; $display("FAIL coll_pending: got %b want 0010", pend); end
        checks++; if (lost !== 4'b0000) begin errors++; $display("FAIL coll_nolost: got %b want 0000", lost); end
        checks++; if (gv !== 1'b0) begin errors++; $display("FAIL coll_valid: got %b want 0", gv); end
        @(negedge clk);
        checks++; if (gv !== 1'b1 || gcode !== 2'b01) begin errors++; $display("FAIL coll_reoffer: got v=%b code=%b want v=1 code=01", gv, gcode); end
        req = 4'b0010;
        @(negedge clk); req = 4'b0000;
        checks++; if (lost !== 4'b0010) begin errors++; $display("FAIL lost_set: got %b want 0010", lost); end
        lost_clr = 1'b1;
        @(negedge clk); lost_clr = 1'b0;
        checks++; if (lost !== 4'b0000) begin errors++; $display("FAIL lost_clr: got %b want 0000", lost); end
        ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        checks++; if (pend !== 4'b0000 || gv !== 1'b0) begin errors++; $display("FAIL coll_drain: got v=%b pend=%b want v=0 pend=0000", gv, pend); end
    endtask

    task automatic test_level();
        do_reset();
        req_b = 4'b0001; ready_b = 1'b1;
        for (int i = 0; i < 6 && gv_b !== 1'b1; i++) @(negedge clk);
        checks++; if (gv_b !== 1'b1) begin errors++; $display("FAIL level_first_grant: got %b want 1 (timeout)", gv_b); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (gv_b !== ((k % 2) == 0)) begin errors++; $display("FAIL level_valid%0d: got %b want %b", k, gv_b, ((k % 2) == 0)); end
            if ((k % 2) == 0) begin
                checks++; if (gcode_b !== 2'b00) begin errors++; $display("FAIL level_code%0d: got %b want 00", k, gcode_b); end
            end
            @(negedge clk);
        end
        req_b = 4'b0000;
        repeat (4) @(negedge clk);
        ready_b = 1'b0;
    endtask

    task automatic test_reset_release();
        int cnt;
        rst = 1'b1; req = 4'b0100; ready = 1'b1; lost_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (gv === 1'b1) begin
                cnt++;
                checks++; if (gcode !== 2'b10) begin errors++; $display("FAIL release_code: got %b want 10", gcode); end
            end
        end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL release_count: got %0d want 1", cnt); end
        req = 4'b0000; ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0110;
        @(negedge clk); req = 4'b0000;
        @(negedge clk);
        checks++; if (gv !== 1'b1 || gcode !== 2'b01 || pend !== 4'b0110) begin errors++; $display("FAIL mid_setup: got v=%b code=%b pend=%b want v=1 code=01 pend=0110", gv, gcode, pend); end
        req = 4'b0110;
        @(negedge clk); req = 4'b0000;
        checks++; if (lost !== 4'b0110) begin errors++; $display("FAIL mid_lost: got %b want 0110", lost); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL mid_pending: got %b want 0000", pend); end
        checks++; if (gv !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", gv); end
        checks++; if (gcode !== 2'b00) begin errors++; $display("FAIL mid_code: got %b want 00", gcode); end
        checks++; if (lost !== 4'b0000) begin errors++; $display("FAIL mid_lost_clr: got %b want 0000", lost); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            checks++; if (pend !== m_pend) begin errors++; $display("FAIL rnd_pending @%0d: got %b want %b", c, pend, m_pend); end
            checks++; if (gv !== m_offer) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", c, gv, m_offer); end
            checks++; if (gcode !== m_code) begin errors++; $display("FAIL rnd_code @%0d: got %b want %b", c, gcode, m_code); end
            checks++; if (lost !== m_lost) begin errors++; $display("FAIL rnd_lost @%0d: got %b want %b", c, lost, m_lost); end
            req      = 4'($urandom) & 4'($urandom);
            ready    = ($urandom_range(0, 2) != 0);
            lost_clr = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 79) == 0);
            @(negedge clk);
        end
        rst = 1'b0; req = 4'b0000; ready = 1'b0; lost_clr = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 4'b0; ready = 1'b0; lost_clr = 1'b0;
        req_b = 4'b0; ready_b = 1'b0; lost_clr_b = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_collision_lost();
        test_level();
        test_reset_release();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_req_latch_v.md
# priority_req_latch_v

Request capture and grant-handshake stage that sits directly upstream of the 4:2 priority encoder (priority_enc_4_2_v). It turns four asynchronous-in-time request strobes into sticky pending bits and drives them into the encoder's `i_code`. It then takes the encoder's `o_code`/`o_valid` back, freezes the winning code into a grant register, and offers it to a consumer over a valid/ready handshake. On acceptance it clears the serviced pending bit, so lower-priority lines are served in turn.

## Interface
- P_EDGE, 1: 1 = a request is captured on a rising edge of `i_req[n]`; 0 = captured whenever `i_req[n]` is high (level mode).
- i_clk  in  1  single clock; all logic on its rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_req  in  4  request lines; line 0 has the highest priority (the encoder enforces this).
- o_pending  out  4  registered pending bits; connect to encoder `i_code`.
- i_enc_code  in  2  encoder `o_code`.
- i_enc_valid  in  1  encoder `o_valid`.
- o_grant_valid  out  1  grant offered to the consumer.
- o_grant_code  out  2  index of the granted line; stable while `o_grant_valid` is high.
- i_grant_ready  in  1  consumer accepts the grant.
- o_lost  out  4  sticky flags; bit n is set when a new capture arrives on line n while it is already pending.
- i_lost_clr  in  1  clears all `o_lost` bits.

## Operation
- Reset: `o_pending`=0, `o_grant_valid`=0, `o_grant_code`=2'b00, `o_lost`=0, edge-history register=0, FSM=IDLE.
  - The edge-history register resets to 0, so a line already high when reset is released counts as an edge in the first cycle.
- Capture: `cap[n]` = `i_req[n] & ~req_q[n]` when P_EDGE=1, and `cap[n]` = `i_req[n]` when P_EDGE=0. `req_q` is `i_req` delayed one cycle.
- Pending update per line, each cycle: `pending_next` = (`pending` & ~`clr`) | `cap`.
  - `clr` is a one-hot of `o_grant_code`, gated by the accept.
  - Set wins over a simultaneous clear on the same line, so no request is dropped.
- Lost: `o_lost[n]` is set when `cap[n]` is high, `pending[n]` is high, and line n is not being cleared in that cycle.
  - `i_lost_clr` has priority over a set in the same cycle.
- FSM, two states:
  - IDLE: `o_grant_valid`=0. If `i_enc_valid`=1, load `o_grant_code` with `i_enc_code` and go to OFFER.
  - OFFER: `o_grant_valid`=1 and `o_grant_code` is held. Higher-priority requests arriving now do not preempt the grant.
    - If `i_grant_ready`=1, clear pending[`o_grant_code`] and return to IDLE.
    - Otherwise stay in OFFER indefinitely.
- Handshake: transfer occurs on any cycle where `o_grant_valid` & `i_grant_ready`. While `o_grant_valid`=0, `i_grant_ready` is ignored.
- The block is used only with the equation-model encoder (purely combinational). `i_enc_*` is sampled in the same cycle that `o_pending` is presented.

## Timing
- Request edge on `i_req` at cycle N, with line idle and FSM in IDLE:
  - `o_pending` bit high at N+1.
  - `o_grant_valid` high at N+2 with the correct code.
- Accept at cycle M: pending bit low and `o_grant_valid` low at M+1. The next grant can be offered at M+2.
  - Maximum throughput is one grant per 2 cycles.
- `o_lost` updates one cycle after the offending capture.
- Reset mid-OFFER: everything returns to reset values at the next edge. In-flight grant and pending bits are discarded without acknowledgment.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Single request: after reset, pulse `i_req`=4'b0100 for one cycle at cycle 2.
  - Required: `o_pending`=4'b0100 at cycle 3; `o_grant_valid`=1 and `o_grant_code`=2'b10 at cycle 4.
  - With `i_grant_ready`=1 at cycle 4: `o_pending`=0 and `o_grant_valid`=0 at cycle 5.
- Priority order: pulse `i_req`=4'b1011 once and hold `i_grant_ready`=1.
  - Required: grants appear in order 2'b00, 2'b01, 2'b11, spaced 2 cycles apart. `o_pending` finally returns to 0.
- No preemption: while OFFER holds code 2'b11 with `i_grant_ready`=0, pulse `i_req[0]`.
  - Required: `o_grant_code` stays 2'b11 until accepted. The next grant is 2'b00.
- Set/clear collision and lost flag:
  - Re-pulse line 1 in the same cycle its grant is accepted. Required: pending[1] stays 1 and `o_lost` stays 0.
  - Pulse line 1 again while it is pending and not being cleared. Required: `o_lost`=4'b0010 at the next cycle; `i_lost_clr` brings it back to 0.
- Level mode and reset release: with P_EDGE=0, hold `i_req`=4'b0001 high.
  - Required: line 0 is re-granted every 2 cycles while `i_grant_ready`=1.
  - With P_EDGE=1 and `i_req[2]` high across the reset release: exactly one grant with code 2'b10.
- Reset mid-operation: assert `i_rst` while in OFFER with `o_pending`=4'b0110.
  - Required: at the next edge, `o_pending`=0, `o_grant_valid`=0, `o_grant_code`=2'b00, `o_lost`=0.
